// File: rtl/l1_cache_ctrl_if.sv
// l1_cache_ctrl_if: CPU request/response and word-wide memory beat signals
// for the L1 cache controller; slave = controller, master = environment.
interface l1_cache_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_rw;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_valid, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_valid, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl: direct-mapped write-back/write-allocate L1, burst refill.
// Define L1_CACHE_STATS_EN for saturating hit_count/miss_count outputs.
module l1_cache_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic clk,
  input  logic reset,
  l1_cache_ctrl_if.slave bus
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int BYTE_BITS  = $clog2(DATA_WIDTH/8);
  localparam int WORD_BITS  = $clog2(WORDS_PER_LINE);
  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   =
    ADDR_WIDTH - INDEX_BITS - WORD_BITS - BYTE_BITS;
  localparam logic [WORD_BITS-1:0] LAST =
    WORD_BITS'(WORDS_PER_LINE - 1);
  localparam logic [WORD_BITS-1:0] WZ = '0;
  localparam logic [BYTE_BITS-1:0] BZ = '0;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND
  } state_t;

  state_t                state;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  mem_valid;
  logic                  mem_rw;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  fill_done;
  logic                  retry;
  logic [WORD_BITS-1:0]  issue_cnt;
  logic [WORD_BITS-1:0]  cap_cnt;
  logic [WORD_BITS-1:0]  issue_nxt;

  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*WORDS_PER_LINE];

  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] idx;
  logic [WORD_BITS-1:0]  woff;
  logic                  hit;
  logic                  unused_addr;

  assign tag  = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
  assign idx  = addr_q[BYTE_BITS+WORD_BITS +: INDEX_BITS];
  assign woff = addr_q[BYTE_BITS +: WORD_BITS];
  assign hit  = valid_q[idx] && (tag_mem[idx] == tag);
  assign issue_nxt   = issue_cnt + 1'b1;
  assign unused_addr = ^addr_q[BYTE_BITS-1:0];

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.mem_valid = mem_valid;
  assign bus.mem_rw    = mem_rw;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

`ifndef L1_CACHE_STATS_EN
  logic unused_retry;
  assign unused_retry = retry;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      fill_done <= 1'b0;
      retry     <= 1'b0;
`ifdef L1_CACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            rw_q      <= bus.req_rw;
            addr_q    <= bus.req_addr;
            wdata_q   <= bus.req_wdata;
            req_ready <= 1'b0;
            retry     <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
`ifdef L1_CACHE_STATS_EN
          if (!retry && hit && hit_count != '1)
            hit_count <= hit_count + 1'b1;
          if (!retry && !hit && miss_count != '1)
            miss_count <= miss_count + 1'b1;
`endif
          if (hit) begin
            if (rw_q) begin
              data_mem[{idx, woff}] <= wdata_q;
              dirty_q[idx] <= 1'b1;
              rsp_rdata    <= '0;
            end else begin
              rsp_rdata <= data_mem[{idx, woff}];
            end
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end else begin
            issue_cnt <= '0;
            cap_cnt   <= '0;
            fill_done <= 1'b0;
            mem_valid <= 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              mem_rw    <= 1'b1;
              mem_addr  <= {tag_mem[idx], idx, WZ, BZ};
              mem_wdata <= data_mem[{idx, WZ}];
              state     <= WRITEBACK;
            end else begin
              mem_rw   <= 1'b0;
              mem_addr <= {tag, idx, WZ, BZ};
              state    <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) begin
            if (issue_cnt == LAST) begin
              issue_cnt <= '0;
              mem_rw    <= 1'b0;
              mem_addr  <= {tag, idx, WZ, BZ};
              state     <= REFILL;
            end else begin
              issue_cnt <= issue_nxt;
              mem_addr  <= {tag_mem[idx], idx, issue_nxt, BZ};
              mem_wdata <= data_mem[{idx, issue_nxt}];
            end
          end
        end
        REFILL: begin
          if (mem_valid && bus.mem_ready) begin
            issue_cnt <= issue_nxt;
            if (issue_cnt == LAST)
              mem_valid <= 1'b0;
            else
              mem_addr <= {tag, idx, issue_nxt, BZ};
          end
          // Commit one cycle after the last beat lands, then retry.
          if (fill_done) begin
            tag_mem[idx] <= tag;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            retry        <= 1'b1;
            fill_done    <= 1'b0;
            state        <= LOOKUP;
          end else if (bus.mem_rvalid) begin
            data_mem[{idx, cap_cnt}] <= bus.mem_rdata;
            cap_cnt <= cap_cnt + 1'b1;
            if (cap_cnt == LAST)
              fill_done <= 1'b1;
          end
        end
        RESPOND: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// tb_l1_cache_ctrl: scoreboard bench for l1_cache_ctrl with a memory model
// that logs every accepted beat and can stall write bursts.
module tb_l1_cache_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  l1_cache_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef L1_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  l1_cache_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef L1_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int last_rv_cyc = 0;
  int last_rsp_cyc = 0;
  int last_lat = 0;
  int stall_req = 0;
  int stall_cnt = 0;
  int stall_checks = 0;

  beat_t       log_q [$];
  exp_t        sb [$];
  logic [31:0] rd_q [$];
  logic [31:0] ext_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a[31:4] == 28'h4) return 32'hA0 + {30'd0, a[3:2]};
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ext_rd(input logic [31:0] a);
    if (ext_mem.exists(a)) return ext_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Memory model: decides ready each cycle, returns reads one cycle later.
  initial begin : mem_model
    logic        pv, pr, pw;
    logic [31:0] pa, pd;
    beat_t       b;
    pv = 1'b0; pr = 1'b1; pw = 1'b0; pa = '0; pd = '0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (rd_q.size() > 0) begin
        bus.mem_rdata  = rd_q.pop_front();
        bus.mem_rvalid = 1'b1;
        last_rv_cyc    = cyc;
      end
      if (pv && !pr && !reset) begin
        checks++;
        stall_checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== pa ||
            bus.mem_wdata !== pd || bus.mem_rw !== pw) begin
          errors++;
          $display("FAIL stall_hold got v=%b a=%h d=%h need a=%h d=%h",
                   bus.mem_valid, bus.mem_addr, bus.mem_wdata, pa, pd);
        end
      end
      if (stall_cnt > 0)
        stall_cnt--;
      else if (stall_req != 0 && bus.mem_valid && bus.mem_rw) begin
        stall_req = 0;
        stall_cnt = 10;
      end
      bus.mem_ready = (stall_cnt == 0);
      pv = bus.mem_valid; pr = bus.mem_ready; pw = bus.mem_rw;
      pa = bus.mem_addr;  pd = bus.mem_wdata;
      if (bus.mem_valid && bus.mem_ready) begin
        b.rw = bus.mem_rw; b.addr = bus.mem_addr; b.data = bus.mem_wdata;
        log_q.push_back(b);
        if (bus.mem_rw) ext_mem[bus.mem_addr] = bus.mem_wdata;
        else rd_q.push_back(ext_rd(bus.mem_addr));
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid.
  initial begin : rsp_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got %h need none", bus.rsp_rdata);
        end else begin
          e = sb.pop_front();
          last_lat = cyc - e.acc;
          if (bus.rsp_rdata !== e.data) begin
            errors++;
            $display("FAIL rsp_data got %h need %h", bus.rsp_rdata, e.data);
          end
        end
      end
    end
  end

  task automatic send(input logic rw, input logic [31:0] a,
                      input logic [31:0] d, input bit keep,
                      output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (bus.req_ready !== 1'b1 && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 300) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready=%b need 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    e.data = rw ? 32'h0 : ref_rd({a[31:2], 2'b00});
    e.acc  = cyc;
    sb.push_back(e);
    if (rw) ref_mem[{a[31:2], 2'b00}] = d;
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout got pending=%0d need 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_beats(input string name, input int base,
                             input logic rw, input logic [31:0] a0);
    checks++;
    if (log_q.size() < base + 4) begin
      errors++;
      $display("FAIL %s_count got %0d need %0d", name,
               log_q.size() - base, 4);
      return;
    end
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      logic [31:0] ea;
      b  = log_q[base+i];
      ea = a0 + 32'(4*i);
      checks++;
      if (b.rw !== rw || b.addr !== ea ||
          (rw && b.data !== ref_rd(ea))) begin
        errors++;
        $display("FAIL %s_beat%0d got rw=%b a=%h d=%h need rw=%b a=%h d=%h",
                 name, i, b.rw, b.addr, b.data, rw, ea,
                 rw ? ref_rd(ea) : 32'h0);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b need 1", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_rsp_valid got %b need 0", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_rdata got %h need 0", bus.rsp_rdata);
    end
    checks++;
    if (bus.mem_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mem_valid got %b need 0", bus.mem_valid);
    end
  endtask

  task automatic test_read_miss();
    int base, w;
    base = log_q.size();
    send(1'b0, 32'h040, '0, 1'b0, w);
    wait_rsp();
    check_beats("miss_refill", base, 1'b0, 32'h040);
    checks++;
    if (last_rsp_cyc - last_rv_cyc != 3) begin
      errors++;
      $display("FAIL miss_latency got %0d need 3",
               last_rsp_cyc - last_rv_cyc);
    end
  endtask

  task automatic test_read_hit();
    int base, w;
    base = log_q.size();
    send(1'b0, 32'h048, '0, 1'b0, w);
    wait_rsp();
    checks++;
    if (log_q.size() != base) begin
      errors++;
      $display("FAIL hit_no_mem got %0d need 0", log_q.size() - base);
    end
    checks++;
    if (last_lat != 2) begin
      errors++; $display("FAIL hit_latency got %0d need 2", last_lat);
    end
`ifdef L1_CACHE_STATS_EN
    checks++;
    if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
      errors++;
      $display("FAIL stats got h=%0d m=%0d need h=1 m=1",
               hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_writeback();
    int base, w;
    base = log_q.size();
    send(1'b1, 32'h044, 32'hDEADBEEF, 1'b0, w);
    wait_rsp();
    checks++;
    if (log_q.size() != base) begin
      errors++;
      $display("FAIL write_hit_no_mem got %0d need 0", log_q.size() - base);
    end
    base = log_q.size();
    send(1'b0, 32'h444, '0, 1'b0, w);
    wait_rsp();
    check_beats("wb", base, 1'b1, 32'h040);
    check_beats("wb_refill", base + 4, 1'b0, 32'h440);
  endtask

  task automatic test_stall();
    int base, w, sc;
    send(1'b1, 32'h44C, 32'h1234_5678, 1'b0, w);
    wait_rsp();
    base = log_q.size();
    sc = stall_checks;
    stall_req = 1;
    send(1'b0, 32'h044, '0, 1'b0, w);
    wait_rsp();
    check_beats("stall_wb", base, 1'b1, 32'h440);
    check_beats("stall_refill", base + 4, 1'b0, 32'h040);
    checks++;
    if (stall_checks - sc < 9) begin
      errors++;
      $display("FAIL stall_cycles got %0d need 9", stall_checks - sc);
    end
  endtask

  task automatic test_reset_mid_refill();
    int base, w, n;
    base = log_q.size();
    send(1'b0, 32'h840, '0, 1'b0, w);
    n = 0;
    while (log_q.size() < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got v=%b r=%b need v=0 r=1",
               bus.mem_valid, bus.req_ready);
    end
    reset = 1'b0;
    base = log_q.size();
    send(1'b0, 32'h840, '0, 1'b0, w);
    wait_rsp();
    check_beats("rereq", base, 1'b0, 32'h840);
  endtask

  task automatic test_back_to_back();
    int w, base;
    base = rsp_cnt;
    send(1'b0, 32'hC80, '0, 1'b1, w);
    send(1'b1, 32'hC84, 32'h55, 1'b0, w);
    checks++;
    if (rsp_cnt != base + 1 || w < 5) begin
      errors++;
      $display("FAIL b2b_order got rsp=%0d waits=%0d need rsp=%0d waits>=5",
               rsp_cnt - base, w, 1);
    end
    send(1'b0, 32'hC84, '0, 1'b0, w);
    wait_rsp();
  endtask

  task automatic test_write_miss();
    int base, w;
    send(1'b0, 32'h3FC, '0, 1'b0, w);
    send(1'b1, 32'h000, 32'hCAFE_0000, 1'b0, w);
    wait_rsp();
    base = log_q.size();
    send(1'b1, 32'h1008, 32'h77, 1'b0, w);
    wait_rsp();
    check_beats("wmiss_wb", base, 1'b1, 32'h000);
    send(1'b0, 32'h1008, '0, 1'b0, w);
    send(1'b0, 32'h000, '0, 1'b0, w);
    wait_rsp();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_miss();
    test_read_hit();
    test_writeback();
    test_stall();
    test_reset_mid_refill();
    test_back_to_back();
    test_write_miss();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
